// File: rtl/serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states, index sizing.
package serial_adder_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ceiling log2, floored at 1 so a single-nibble build still has an index bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/ripple_adder.sv
// 4-bit adder slice shared by the serial controller, one nibble per cycle.
module ripple_adder
   import serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   assign {cout, sum} = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(cin);

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder that time-multiplexes one 4-bit slice, LSB nibble first, with valid/ready on both sides.
// Optional subtract mode (sub input, ovf output) is enabled by NIBBLE_SERIAL_SUB_EN.
module nibble_serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]   op_a,
   input  logic [NIBBLE_W*NIBBLES-1:0]   op_b,
   input  logic                          op_cin,
`ifdef NIBBLE_SERIAL_SUB_EN
   input  logic                          sub,
   output logic                          ovf,
`endif
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0]   result,
   output logic                          cout,
   output logic                          busy
);

   localparam int unsigned IW = clog2(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES-1);

   state_t                            state;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]  a_q;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]  b_q;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]  res_q;
   logic [IW-1:0]                     idx;
   logic                              carry;

   logic [NIBBLE_W-1:0]               slice_a;
   logic [NIBBLE_W-1:0]               slice_b;
   logic [NIBBLE_W-1:0]               slice_sum;
   logic                              slice_cout;

`ifdef NIBBLE_SERIAL_SUB_EN
   logic                              sub_q;
   logic                              top_cin;

   // Subtract is A + ~B + 1; carry into the MSB is recovered from the sum bit.
   always_comb begin
      slice_a = a_q[idx];
      slice_b = b_q[idx] ^ {NIBBLE_W{sub_q}};
      top_cin = slice_sum[NIBBLE_W-1] ^ slice_a[NIBBLE_W-1] ^ slice_b[NIBBLE_W-1];
   end
`else
   always_comb begin
      slice_a = a_q[idx];
      slice_b = b_q[idx];
   end
`endif

   ripple_adder u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   assign result = res_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         res_q     <= '0;
         cout      <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
         sub_q     <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q      <= op_a;
                  b_q      <= op_b;
                  idx      <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
                  sub_q    <= sub;
                  carry    <= sub | op_cin;
`else
                  carry    <= op_cin;
`endif
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               res_q[idx] <= slice_sum;
               carry      <= slice_cout;
               idx        <= idx + IW'(1);
               if (idx == LAST_IDX) begin
                  cout      <= slice_cout;
`ifdef NIBBLE_SERIAL_SUB_EN
                  ovf       <= top_cin ^ slice_cout;
`endif
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencing controller that performs wide additions of NIBBLES*4 bits by time-multiplexing a single 4-bit ripple_adder slice (ports a, b, cin, sum, cout), one nibble per cycle, LSB nibble first. The carry is registered between cycles. Operands enter and the result leaves through valid/ready handshakes. It sits between the operand source and the result consumer, and is the only user of its adder slice.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operand source has a transaction
in_ready  output  1  controller can accept a transaction (high only in IDLE)
op_a  input  W  operand A
op_b  input  W  operand B
op_cin  input  1  carry-in to nibble 0
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
result  output  W  sum
cout  output  1  carry-out of the top nibble
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, busy=0, nibble index=0, carry reg=0. Reset has priority over all other events, including in RUN or DONE; any in-flight transaction is discarded.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, latch op_a, op_b, op_cin into internal registers, set idx=0 and carry=op_cin, then go to RUN.
  - result and cout keep their last values.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle the slice is driven with a=A[idx], b=B[idx], cin=carry.
  - At the edge: result nibble idx <= sum, carry <= slice cout, idx <= idx+1.
  - When idx==NIBBLES-1: cout <= slice cout and go to DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_valid=1; result and cout are held stable.
  - On out_ready at an edge, go to IDLE with out_valid=0.
  - in_ready is not asserted in DONE (no overlap).
- Latency: the acceptance edge is E0; out_valid becomes high after edge E0+NIBBLES.
- Minimum transaction period is NIBBLES+2 cycles when out_ready is held high.
- Result nibbles above idx are don't-care during RUN but must not glitch outward: result is only valid while out_valid=1.
- NIBBLES=1: RUN lasts one cycle, so the block behaves as a registered 4-bit add.
- The carry is unsigned; the wrap of the top nibble is reported only via cout.
- Latched operands are immune to changes on op_a/op_b/op_cin after acceptance.

Optional Feature:
Macro NIBBLE_SERIAL_SUB_EN.
- Defined: adds input sub (1 bit, latched with the operands) and output ovf (1 bit).
  - sub=1: the slice sees ~B[idx] and the initial carry is 1; op_cin is ignored.
  - ovf is the two's-complement overflow of the top nibble, computed as (carry into bit W-1) XOR (carry out of bit W-1). It is registered with cout and reset to 0.
  - cout on subtract means "no borrow".
- Undefined: the sub and ovf ports do not exist, and the datapath is add-only.

Decomposition:
- Package serial_adder_pkg:
  - NIBBLE_W=4
  - state typedef/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - index width function clog2(NIBBLES)
- Sub-module: the existing ripple_adder, instantiated once as the arithmetic slice. FSM, operand registers and result assembly stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with random inputs -> in_ready=1, out_valid=0, busy=0, result=0x0000, cout=0.
2. With out_ready=1, add 0x1234+0x4321, cin=0 -> result 0x5555, cout=0; out_valid rises exactly 4 cycles after the acceptance edge.
3. Add 0xFFFF+0x0000, cin=1 -> result 0x0000, cout=1, confirming carry propagation through all 4 nibbles.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and cout stay stable and in_ready=0. A new in_valid with 0xAAAA is not accepted until one cycle after out_ready=1.
5. Assert rst_n=0 after 2 RUN cycles -> IDLE with all outputs at reset values. Then add 0x00FF+0x0001 -> result 0x0100, cout=0.
6. With NIBBLE_SERIAL_SUB_EN defined:
   - 0x0005-0x0007, sub=1 -> result 0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001 -> result 0x7FFF, cout=1, ovf=1.
